// File: rtl/avalon_mm_slave_ram.sv
// avalon_mm_slave_ram
//   Avalon-MM responder backed by a word-addressed synchronous RAM. Each
//   transfer is held off with WAITREQUEST for WAIT_STATES cycles and is then
//   acknowledged for exactly one cycle. It is used as on-chip instruction or
//   data memory in system-level simulation, in place of the external fabric.
//
// Ports
//   CLK            clock; all state changes on the rising edge
//   RST_N          asynchronous active-low reset
//   ADDRESS        byte address from the master
//   BEGINTRANSFER  first-cycle marker from the master
//   READ / WRITE   requests, held by the master until acknowledged
//   WRITEDATA      write data, valid while WRITE=1
//   LOCK           master asks for the bus lock on this transfer
//   READDATA       read data; valid in the ACK cycle and held afterwards
//   WAITREQUEST    0 for exactly one (registered) cycle per transfer
//   LOCKED         lock status, updated at each ACK
//   ERR            one-cycle pulse on a protocol or decode error
module avalon_mm_slave_ram #(
  parameter int unsigned      width       = 32,
  parameter int unsigned      DEPTH_LOG2  = 10,
  parameter logic [31:0]      BASE_ADDR   = 32'h0,
  parameter int unsigned      WAIT_STATES = 1,
  parameter logic [width-1:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      ADDRESS,
  input  logic             BEGINTRANSFER,
  input  logic             READ,
  input  logic             WRITE,
  input  logic [width-1:0] WRITEDATA,
  input  logic             LOCK,
  output logic [width-1:0] READDATA,
  output logic             WAITREQUEST,
  output logic             LOCKED,
  output logic             ERR
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_INIT  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_d;
  logic                  load_rd;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_hit;

  logic [width-1:0]      mem [0:DEPTH-1];

  // Transfer context captured at accept; later ADDRESS/WRITEDATA changes are ignored.
  logic                  op_wr_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  hit_q;
  logic [width-1:0]      wdata_q;
  logic                  lock_q;

  // Address decode. The window test is done on the offset in 33 bits so a
  // window that ends at the top of the address space cannot wrap.
  logic [31:0]           offset;
  logic                  dec_hit;
  logic                  dec_misaligned;
  logic [DEPTH_LOG2-1:0] dec_idx;

  assign offset         = ADDRESS - BASE_ADDR;
  assign dec_hit        = (ADDRESS >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
  assign dec_idx        = offset[DEPTH_LOG2+1:2];
  assign dec_misaligned = |ADDRESS[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    load_rd = 1'b0;
    rd_idx  = idx_q;
    rd_hit  = hit_q;
    unique case (state_q)
      S_IDLE: begin
        // With zero wait states the RAM is read straight from the live decode.
        rd_idx = dec_idx;
        rd_hit = dec_hit;
        if (READ && WRITE) begin
          err_d = 1'b1;
        end else if (READ || WRITE) begin
          if (dec_misaligned) err_d = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
            load_rd = READ;
            if (!dec_hit) err_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!READ && !WRITE) begin
          // Master withdrew the request: abandon the transfer silently.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          load_rd = !op_wr_q;
          if (!hit_q) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && BEGINTRANSFER) err_d = 1'b1;
  end

  // Control and output registers. WAITREQUEST is derived from the next
  // state so it is a flop output with no combinational path from inputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      READDATA    <= '0;
      WAITREQUEST <= 1'b1;
      LOCKED      <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      WAITREQUEST <= (state_d != S_ACK);
      ERR         <= err_d;
      if (load_rd) READDATA <= rd_hit ? mem[rd_idx] : ERR_DATA;
      if (state_q == S_ACK) LOCKED <= lock_q;
    end
  end

  // Data path: transfer context and RAM write. A write commits only at the
  // end of ACK, so a reset or abort before then leaves the RAM untouched.
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && (READ ^ WRITE)) begin
      op_wr_q <= WRITE;
      idx_q   <= dec_idx;
      hit_q   <= dec_hit;
      wdata_q <= WRITEDATA;
      lock_q  <= LOCK;
    end
    if (state_q == S_ACK && op_wr_q && hit_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_avalon_mm_slave_ram.sv
// tb_avalon_mm_slave_ram
//   Bench for avalon_mm_slave_ram. Three instances cover WAIT_STATES 1, 0
//   and 3 (the WAIT_STATES=0 one with a non-zero base). A per-instance
//   reference memory predicts read data, error pulses, latency and LOCKED.
module tb_avalon_mm_slave_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        rd    [3];
  logic        wr    [3];
  logic        bt    [3];
  logic        lk    [3];
  logic        wreq  [3];
  logic        lkd   [3];
  logic        err   [3];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  int          ws_m   [3] = '{1, 0, 3};
  logic [31:0] base_m [3] = '{32'h0000_0000, 32'h0000_2000, 32'h0000_0000};
  logic [31:0] mem_m  [3][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_mm_slave_ram #(.width(32), .DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000),
                        .WAIT_STATES(1), .ERR_DATA(32'hDEADBEEF)) u_ws1 (
    .CLK(clk), .RST_N(rst_n), .ADDRESS(addr[0]), .BEGINTRANSFER(bt[0]),
    .READ(rd[0]), .WRITE(wr[0]), .WRITEDATA(wdata[0]), .LOCK(lk[0]),
    .READDATA(rdata[0]), .WAITREQUEST(wreq[0]), .LOCKED(lkd[0]), .ERR(err[0]));

  avalon_mm_slave_ram #(.width(32), .DEPTH_LOG2(10), .BASE_ADDR(32'h0000_2000),
                        .WAIT_STATES(0), .ERR_DATA(32'hDEADBEEF)) u_ws0 (
    .CLK(clk), .RST_N(rst_n), .ADDRESS(addr[1]), .BEGINTRANSFER(bt[1]),
    .READ(rd[1]), .WRITE(wr[1]), .WRITEDATA(wdata[1]), .LOCK(lk[1]),
    .READDATA(rdata[1]), .WAITREQUEST(wreq[1]), .LOCKED(lkd[1]), .ERR(err[1]));

  avalon_mm_slave_ram #(.width(32), .DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000),
                        .WAIT_STATES(3), .ERR_DATA(32'hDEADBEEF)) u_ws3 (
    .CLK(clk), .RST_N(rst_n), .ADDRESS(addr[2]), .BEGINTRANSFER(bt[2]),
    .READ(rd[2]), .WRITE(wr[2]), .WRITEDATA(wdata[2]), .LOCK(lk[2]),
    .READDATA(rdata[2]), .WAITREQUEST(wreq[2]), .LOCKED(lkd[2]), .ERR(err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One master transfer on instance s. Returns the read data seen in the
  // acknowledge cycle, the number of cycles after accept until acknowledge,
  // whether ERR was seen, and the cycle stamp of the acknowledge.
  task automatic xfer(input int s, input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                      input bit l, input bit bt_hold, output logic [31:0] rv,
                      output int lat, output bit es, output int ack_cyc);
    @(negedge clk);
    addr[s] = a; wdata[s] = d; rd[s] = !is_wr; wr[s] = is_wr; lk[s] = l; bt[s] = 1'b1;
    lat = 0; es = 1'b0; rv = 'x; ack_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i >= (bt_hold ? 1 : 0)) bt[s] = 1'b0;
      lat++;
      if (err[s]) es = 1'b1;
      if (!wreq[s]) begin
        rv = rdata[s];
        ack_cyc = cyc;
        break;
      end
    end
    bt[s] = 1'b0;
    @(posedge clk);
    #1;
    rd[s] = 1'b0; wr[s] = 1'b0;
  endtask

  // Transfer plus comparison against the reference memory.
  task automatic op(input int s, input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                    input bit l, input bit bt_hold, input string tag, output int ack_cyc);
    logic [31:0] rv;
    int          lat;
    bit          es;
    longint      off;
    bit          hit;
    int          w;
    bit          exp_err;
    off     = longint'({32'b0, a}) - longint'({32'b0, base_m[s]});
    hit     = (off >= 0) && (off < 4096);
    w       = int'((off >>> 2) & 1023);
    exp_err = !hit || (a[1:0] != 2'b00) || bt_hold;
    xfer(s, is_wr, a, d, l, bt_hold, rv, lat, es, ack_cyc);
    check({tag, ".lat"}, 32'(lat), 32'(1 + ws_m[s]));
    check({tag, ".err"}, 32'(es), 32'(exp_err));
    if (!is_wr) check({tag, ".rdata"}, rv, hit ? mem_m[s][w] : 32'hDEADBEEF);
    else if (hit) mem_m[s][w] = d;
    check({tag, ".locked"}, 32'(lkd[s]), 32'(l));
  endtask

  initial begin
    int ac0, ac1, ac2;
    int errs, lows;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      addr[s] = '0; wdata[s] = '0; rd[s] = 0; wr[s] = 0; bt[s] = 0; lk[s] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst.wreq", 32'(wreq[0]), 32'd1);
    check("rst.rdata", rdata[0], 32'd0);
    rst_n = 1'b1;

    // Idle after reset release.
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) errs += int'(err[s]) + int'(!wreq[s]);
    end
    check("idle.activity", 32'(errs), 32'd0);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("idle%0d.wreq", s), 32'(wreq[s]), 32'd1);
      check($sformatf("idle%0d.rdata", s), rdata[s], 32'd0);
      check($sformatf("idle%0d.locked", s), 32'(lkd[s]), 32'd0);
    end

    // One wait state: write then read back.
    op(0, 1, 32'h10, 32'hCAFEF00D, 0, 0, "ws1.wr10", ac0);
    op(0, 0, 32'h10, 32'h0, 0, 0, "ws1.rd10", ac0);

    // Zero wait states: back-to-back reads acknowledge every second cycle.
    op(1, 1, 32'h2000, 32'd1, 0, 0, "ws0.wr0", ac0);
    op(1, 1, 32'h2004, 32'd2, 0, 0, "ws0.wr4", ac0);
    op(1, 1, 32'h2008, 32'd3, 0, 0, "ws0.wr8", ac0);
    op(1, 0, 32'h2000, 32'h0, 0, 0, "ws0.rd0", ac0);
    op(1, 0, 32'h2004, 32'h0, 0, 0, "ws0.rd4", ac1);
    op(1, 0, 32'h2008, 32'h0, 0, 0, "ws0.rd8", ac2);
    check("ws0.gap1", 32'(ac1 - ac0), 32'd2);
    check("ws0.gap2", 32'(ac2 - ac1), 32'd2);

    // Out-of-window accesses, including the aliasing word and below base.
    op(0, 1, 32'h0, 32'h1234_5678, 0, 0, "oow.pre", ac0);
    op(0, 0, 32'h1000, 32'h0, 0, 0, "oow.rd", ac0);
    op(0, 1, 32'h1000, 32'hBAD0_BAD0, 0, 0, "oow.wr", ac0);
    op(0, 0, 32'h0, 32'h0, 0, 0, "oow.unchanged", ac0);
    op(1, 0, 32'h1FFC, 32'h0, 0, 0, "oow.below", ac0);
    op(1, 0, 32'h2FFC, 32'h0, 0, 0, "oow.lastword", ac0);

    // Abort in WAIT: the write must not commit.
    op(2, 1, 32'h20, 32'h11, 0, 0, "abort.pre", ac0);
    @(negedge clk);
    addr[2] = 32'h20; wdata[2] = 32'h55; wr[2] = 1; bt[2] = 1;
    @(negedge clk);
    bt[2] = 0;
    @(negedge clk);
    wr[2] = 0;
    lows = 0; errs = 0;
    repeat (6) begin
      @(negedge clk);
      lows += int'(!wreq[2]); errs += int'(err[2]);
    end
    check("abort.noack", 32'(lows), 32'd0);
    check("abort.noerr", 32'(errs), 32'd0);
    op(2, 0, 32'h20, 32'h0, 1, 0, "abort.read", ac0);

    // Reset in WAIT: outputs return to reset values, write not committed.
    @(negedge clk);
    addr[2] = 32'h20; wdata[2] = 32'h55; wr[2] = 1; bt[2] = 1;
    @(negedge clk);
    bt[2] = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstw.wreq", 32'(wreq[2]), 32'd1);
    check("rstw.rdata", rdata[2], 32'd0);
    check("rstw.err", 32'(err[2]), 32'd0);
    check("rstw.locked", 32'(lkd[2]), 32'd0);
    @(negedge clk);
    wr[2] = 0;
    rst_n = 1'b1;
    op(2, 0, 32'h20, 32'h0, 0, 0, "rstw.read", ac0);

    // READ and WRITE together: error, never acknowledged.
    @(negedge clk);
    addr[0] = 32'h10; rd[0] = 1; wr[0] = 1; bt[0] = 1;
    lows = 0; errs = 0;
    repeat (4) begin
      @(negedge clk);
      bt[0] = 0;
      lows += int'(!wreq[0]); errs += int'(err[0]);
    end
    rd[0] = 0; wr[0] = 0;
    check("both.noack", 32'(lows), 32'd0);
    check("both.err", 32'(errs > 0), 32'd1);

    // Misaligned read, BEGINTRANSFER while busy, lock set and cleared.
    op(0, 0, 32'h13, 32'h0, 0, 0, "misalign", ac0);
    op(2, 0, 32'h20, 32'h0, 0, 1, "btbusy", ac0);
    op(0, 0, 32'h10, 32'h0, 1, 0, "lock.on", ac0);
    op(0, 0, 32'h10, 32'h0, 0, 0, "lock.off", ac0);

    // Randomized traffic against the reference memory.
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 16; w++)
        op(s, 1, base_m[s] + 32'(w * 4), $urandom, 0, 0, "pre", ac0);
    for (int n = 0; n < 120; n++) begin
      int          s;
      logic [31:0] a;
      s = n % 3;
      a = base_m[s] + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
      op(s, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), 0,
         $sformatf("rnd%0d", n), ac0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
